// File: rtl/seq_alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seq_alu_pkg
// Purpose  : Function-select codes and control FSM encoding for seq_alu.
// Revision : 1.0
// ============================================================================
package seq_alu_pkg;

    localparam logic [2:0] FN_ADD  = 3'd0;
    localparam logic [2:0] FN_SUB  = 3'd1;
    localparam logic [2:0] FN_AND  = 3'd2;
    localparam logic [2:0] FN_OR   = 3'd3;
    localparam logic [2:0] FN_MUL  = 3'd4;
    localparam logic [2:0] FN_NOT  = 3'd5;
    localparam logic [2:0] FN_PASS = 3'd6;
    localparam logic [2:0] FN_XOR  = 3'd7;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/seq_alu_if.sv
`default_nettype none
// ============================================================================
// Module   : seq_alu_if
// Purpose  : Request/result bundle between the control FSM and seq_alu.
// Revision : 1.0
// ============================================================================
interface seq_alu_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [2:0]       fnsel;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] z;
    logic             c_n;
    logic             c_n_minus_1;
    logic             ovf;
    logic             zero;
    logic             neg;

    modport master (
        output start, fnsel, x, y,
        input  busy, done, z, c_n, c_n_minus_1, ovf, zero, neg
    );

    modport slave (
        input  start, fnsel, x, y,
        output busy, done, z, c_n, c_n_minus_1, ovf, zero, neg
    );
endinterface
`default_nettype wire

// File: rtl/seq_alu_mul.sv
`default_nettype none
// ============================================================================
// Module   : seq_alu_mul
// Purpose  : Iterative shift-add multiplier datapath, one multiplier bit/cycle.
// Revision : 1.0
// ============================================================================
module seq_alu_mul #(
    parameter int WIDTH = 16
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_load,
    input  wire logic             i_step,
    input  wire logic [WIDTH-1:0] i_x,
    input  wire logic [WIDTH-1:0] i_y,
    output logic      [WIDTH-1:0] o_prod,
    output logic                  o_upper_nz,
    output logic                  o_last
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] C_CNT_INIT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [CNT_W-1:0]   r_cnt;
    logic [2*WIDTH-1:0] w_acc_next;

    assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
        end else if (i_load) begin
            r_acc    <= '0;
            r_mcand  <= {{WIDTH{1'b0}}, i_x};
            r_mplier <= i_y;
            r_cnt    <= C_CNT_INIT;
        end else if (i_step) begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt - C_CNT_ONE;
        end
    end

    // The final product is taken from the accumulator's next value so the
    // last iteration and the result register share one edge.
    assign o_prod     = w_acc_next[WIDTH-1:0];
    assign o_upper_nz = |w_acc_next[2*WIDTH-1:WIDTH];
    assign o_last     = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/seq_alu.sv
`default_nettype none
// ============================================================================
// Module   : seq_alu
// Purpose  : Multicycle ALU with registered result/flags and start/done
//            handshake. Define SEQ_ALU_MUL_EN to build the iterative multiply.
// Revision : 1.0
// ============================================================================
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  wire logic clk,
    input  wire logic reset,
    seq_alu_if.slave  bus
);
    logic [WIDTH-1:0] w_yb;
    logic             w_cin;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_lo;

    logic [WIDTH-1:0] w_res_z;
    logic             w_res_cn;
    logic             w_res_cm1;
    logic             w_res_ovf;

    logic             w_issue;
    logic             w_finish;
    logic [WIDTH-1:0] w_mul_z;
    logic             w_mul_unz;

    logic [WIDTH-1:0] r_z;
    logic             r_cn;
    logic             r_cm1;
    logic             r_ovf;
    logic             r_done;

    // One adder serves ADD and SUB: fnsel[0] inverts y and supplies carry-in.
    assign w_cin = bus.fnsel[0];
    assign w_yb  = bus.y ^ {WIDTH{w_cin}};
    assign w_sum = {1'b0, bus.x} + {1'b0, w_yb} + {{WIDTH{1'b0}}, w_cin};
    assign w_lo  = {1'b0, bus.x[WIDTH-2:0]} + {1'b0, w_yb[WIDTH-2:0]}
                 + {{(WIDTH-1){1'b0}}, w_cin};

    always_comb begin
        w_res_z   = '0;
        w_res_cn  = 1'b0;
        w_res_cm1 = 1'b0;
        w_res_ovf = 1'b0;
        case (bus.fnsel)
            FN_ADD, FN_SUB: begin
                w_res_z   = w_sum[WIDTH-1:0];
                w_res_cn  = w_sum[WIDTH];
                w_res_cm1 = w_lo[WIDTH-1];
                w_res_ovf = w_sum[WIDTH] ^ w_lo[WIDTH-1];
            end
            FN_AND:  w_res_z = bus.x & bus.y;
            FN_OR:   w_res_z = bus.x | bus.y;
            FN_NOT:  w_res_z = ~bus.x;
            FN_PASS: w_res_z = bus.x;
            FN_XOR:  w_res_z = bus.x ^ bus.y;
            FN_MUL:  w_res_z = '0;
            default: w_res_z = '0;
        endcase
    end

`ifdef SEQ_ALU_MUL_EN
    state_t r_state;
    state_t w_state_next;
    logic   w_load;
    logic   w_step;
    logic   w_mul_last;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_issue      = 1'b0;
        w_load       = 1'b0;
        w_step       = 1'b0;
        w_finish     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    if (bus.fnsel == FN_MUL) begin
                        w_load       = 1'b1;
                        w_state_next = ST_MUL;
                    end else begin
                        w_issue = 1'b1;
                    end
                end
            end
            ST_MUL: begin
                w_step = 1'b1;
                if (w_mul_last) begin
                    w_finish     = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    seq_alu_mul #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk        (clk),
        .rst        (reset),
        .i_load     (w_load),
        .i_step     (w_step),
        .i_x        (bus.x),
        .i_y        (bus.y),
        .o_prod     (w_mul_z),
        .o_upper_nz (w_mul_unz),
        .o_last     (w_mul_last)
    );

    assign bus.busy = (r_state == ST_MUL);
`else
    // Without the multiplier every function, including fnsel=4, is one cycle.
    assign w_issue   = bus.start;
    assign w_finish  = 1'b0;
    assign w_mul_z   = '0;
    assign w_mul_unz = 1'b0;
    assign bus.busy  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_z    <= '0;
            r_cn   <= 1'b0;
            r_cm1  <= 1'b0;
            r_ovf  <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= w_issue | w_finish;
            if (w_issue) begin
                r_z   <= w_res_z;
                r_cn  <= w_res_cn;
                r_cm1 <= w_res_cm1;
                r_ovf <= w_res_ovf;
            end else if (w_finish) begin
                r_z   <= w_mul_z;
                r_cn  <= w_mul_unz;
                r_cm1 <= 1'b0;
                r_ovf <= 1'b0;
            end
        end
    end

    assign bus.done        = r_done;
    assign bus.z           = r_z;
    assign bus.c_n         = r_cn;
    assign bus.c_n_minus_1 = r_cm1;
    assign bus.ovf         = r_ovf;
    assign bus.zero        = (r_z == '0);
    assign bus.neg         = r_z[WIDTH-1];

endmodule
`default_nettype wire
